clk_div_multi: RTL and testbench

//  NCH-channel programmable clock-enable/tick generator with per-channel divisor and output mode.

---
 rtl/clk_div_multi_pkg.sv | 17 +
 rtl/clk_div_multi_chan.sv | 81 ++++++++
 rtl/clk_div_multi.sv | 48 ++++
 tb/tb_clk_div_multi.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package clk_div_multi_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Never returns less than 1, so a single-channel build still has a legal select port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: period counter, active/pending config and registered tick/LED.
module clk_div_multi_chan
  import clk_div_multi_pkg::*;
#(
  parameter int   CNT_W    = 16,
  parameter int   DEF_DIV  = 50000,
  parameter logic DEF_MODE = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic             en,
  input  logic             sync_clr,
  output logic             tick,
  output logic             led,
  output logic             busy
);

  logic [CNT_W-1:0] cnt, act_div, pend_div;
  mode_e            act_mode, pend_mode;
  logic             pend;

  logic [CNT_W-1:0] deff, cnt_next, new_div;
  mode_e            new_mode, eff_mode;
  logic             wrap, apply, load, led_next;

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    deff     = (act_div < CNT_W'(2)) ? CNT_W'(1) : act_div;
    wrap     = en && !sync_clr && (cnt == deff - CNT_W'(1));
    apply    = wrap || !en || sync_clr;
    load     = apply && (we || pend);
    // A write landing in an apply cycle bypasses the pending registers.
    new_div  = we ? cfg_div : pend_div;
    new_mode = we ? mode_e'(cfg_mode) : pend_mode;
    eff_mode = load ? new_mode : act_mode;

    cnt_next = '0;
    if (en && !sync_clr && !wrap) cnt_next = cnt + CNT_W'(1);

    led_next = led;
    if (sync_clr)                              led_next = 1'b0;
    else if (eff_mode == MODE_PULSE)           led_next = wrap;
    else if (load && act_mode == MODE_PULSE)   led_next = 1'b0;
    else if (wrap)                             led_next = ~led;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt       <= '0;
      act_div   <= CNT_W'(DEF_DIV);
      act_mode  <= mode_e'(DEF_MODE);
      pend_div  <= '0;
      pend_mode <= MODE_TOGGLE;
      pend      <= 1'b0;
      tick      <= 1'b0;
      led       <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= wrap;
      led  <= led_next;
      if (load) begin
        act_div  <= new_div;
        act_mode <= new_mode;
      end
      if (apply) begin
        pend <= 1'b0;
      end else if (we) begin
        pend      <= 1'b1;
        pend_div  <= cfg_div;
        pend_mode <= mode_e'(cfg_mode);
      end
    end
  end

  assign busy = pend;

endmodule

// File: rtl/clk_div_multi.sv
// NCH-channel programmable tick generator: config select decode and per-channel fan-out.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 50000,
  parameter int DEF_MODE = 0,
  localparam int CH_W    = clog2(NCH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [NCH-1:0]   en,
  input  logic             sync_clr,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   LED_Out,
  output logic [NCH-1:0]   busy
);

  logic [NCH-1:0] ch_we;

  // Selects at or above NCH match no channel and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_multi_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_MODE(1'(DEF_MODE))
    ) u_chan (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .we      (ch_we[i]),
      .cfg_div (cfg_div),
      .cfg_mode(cfg_mode),
      .en      (en[i]),
      .sync_clr(sync_clr),
      .tick    (tick[i]),
      .led     (LED_Out[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: three channels, default divisor 4, toggle mode.
module tb_clk_div_multi;

  localparam int NCH   = 3;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_mode = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic             sync_clr = 1'b0;
  logic [NCH-1:0]   tick, LED_Out, busy;

  int checks = 0;
  int failures = 0;

  clk_div_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(4), .DEF_MODE(0)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .en(en), .sync_clr(sync_clr), .tick(tick),
    .LED_Out(LED_Out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    en = '0; cfg_we = 1'b0; sync_clr = 1'b0; RSTn = 1'b0;
    repeat (2) step();
    RSTn = 1'b1;
  endtask

  task automatic write_step(input logic [1:0] ch, input logic [CNT_W-1:0] d, input logic m);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = d; cfg_mode = m;
    step();
    cfg_we = 1'b0;
  endtask

  // Returns the number of cycles until tick[ch] is seen high, or -1 on timeout.
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick[ch] !== 1'b1 && n < limit);
    if (tick[ch] !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; en = '0;
    repeat (2) step();
    checks++;
    if ({tick, LED_Out, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got tick=%b led=%b busy=%b want all 0", tick, LED_Out, busy);
    end
  endtask

  task automatic test_basic();
    logic [NCH-1:0] exp_t, exp_l;
    do_reset();
    en = '1;
    for (int s = 1; s <= 12; s++) begin
      step();
      exp_t = (s % 4 == 0) ? '1 : '0;
      exp_l = ((s / 4) % 2 == 1) ? '1 : '0;
      checks++;
      if (tick !== exp_t || LED_Out !== exp_l) begin
        failures++;
        $display("FAIL basic step=%0d got tick=%b led=%b want tick=%b led=%b", s, tick, LED_Out, exp_t, exp_l);
      end
    end
  endtask

  task automatic test_cfg_pending();
    logic [NCH-1:0] exp_t;
    do_reset();
    en = '1;
    repeat (2) step();
    write_step(2'd1, 16'd10, 1'b0);
    checks++;
    if (busy !== 3'b010 || tick !== 3'b000) begin
      failures++;
      $display("FAIL pend_busy got busy=%b tick=%b want busy=010 tick=000", busy, tick);
    end
    step();
    checks++;
    if (busy !== 3'b000 || tick !== 3'b111) begin
      failures++;
      $display("FAIL pend_apply got busy=%b tick=%b want busy=000 tick=111", busy, tick);
    end
    for (int r = 1; r <= 10; r++) begin
      step();
      exp_t = {r % 4 == 0, r == 10, r % 4 == 0};
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL pend_period r=%0d got tick=%b want %b", r, tick, exp_t);
      end
    end
  endtask

  task automatic test_small_div();
    int n;
    do_reset();
    en = 3'b011;
    write_step(2'd2, 16'd0, 1'b0);
    en = '1;
    for (int r = 1; r <= 4; r++) begin
      step();
      checks++;
      if (tick[2] !== 1'b1) begin
        failures++;
        $display("FAIL div0 r=%0d got tick2=%b want 1", r, tick[2]);
      end
    end
    write_step(2'd2, 16'd1, 1'b0);
    checks++;
    if (tick[2] !== 1'b1 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL div1_write got tick2=%b busy2=%b want 1 0", tick[2], busy[2]);
    end
    for (int r = 1; r <= 3; r++) begin
      step();
      checks++;
      if (tick[2] !== 1'b1) begin
        failures++;
        $display("FAIL div1 r=%0d got tick2=%b want 1", r, tick[2]);
      end
    end
    write_step(2'd2, 16'hFFFF, 1'b0);
    wait_tick(2, 70000, n);
    checks++;
    if (n !== 65535) begin
      failures++;
      $display("FAIL div_max_period got %0d cycles want 65535", n);
    end
  endtask

  task automatic test_bad_ch_and_wrap();
    int n;
    do_reset();
    en = '1;
    write_step(2'd3, 16'd7, 1'b1);
    checks++;
    if (busy !== 3'b000) begin
      failures++;
      $display("FAIL bad_ch_busy got %b want 000", busy);
    end
    repeat (3) step();
    checks++;
    if (tick !== 3'b111 || LED_Out !== 3'b111) begin
      failures++;
      $display("FAIL bad_ch_run got tick=%b led=%b want 111 111", tick, LED_Out);
    end
    repeat (7) step();
    write_step(2'd0, 16'd6, 1'b0);
    checks++;
    if (tick !== 3'b111 || busy !== 3'b000) begin
      failures++;
      $display("FAIL wrap_write got tick=%b busy=%b want 111 000", tick, busy);
    end
    wait_tick(0, 20, n);
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL wrap_write_period got %0d want 6", n);
    end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    en = '1;
    repeat (6) step();
    en = 3'b110;
    for (int r = 1; r <= 7; r++) begin
      step();
      checks++;
      if (tick[0] !== 1'b0 || LED_Out[0] !== 1'b1) begin
        failures++;
        $display("FAIL en_low r=%0d got tick0=%b led0=%b want 0 1", r, tick[0], LED_Out[0]);
      end
    end
    en = '1;
    wait_tick(0, 20, n);
    checks++;
    if (n !== 4 || LED_Out[0] !== 1'b0) begin
      failures++;
      $display("FAIL en_rise got %0d cycles led0=%b want 4 0", n, LED_Out[0]);
    end
  endtask

  task automatic test_mode();
    logic e;
    do_reset();
    en = 3'b011;
    write_step(2'd2, 16'd2, 1'b1);
    en = '1;
    for (int r = 1; r <= 6; r++) begin
      step();
      e = (r % 2 == 0);
      checks++;
      if (tick[2] !== e || LED_Out[2] !== e) begin
        failures++;
        $display("FAIL pulse r=%0d got tick2=%b led2=%b want %b", r, tick[2], LED_Out[2], e);
      end
    end
    write_step(2'd2, 16'd2, 1'b0);
    checks++;
    if (busy[2] !== 1'b1) begin
      failures++;
      $display("FAIL mode_busy got %b want 1", busy[2]);
    end
    step();
    checks++;
    if (tick[2] !== 1'b1 || LED_Out[2] !== 1'b0) begin
      failures++;
      $display("FAIL mode_to_toggle got tick2=%b led2=%b want 1 0", tick[2], LED_Out[2]);
    end
    repeat (2) step();
    checks++;
    if (LED_Out[2] !== 1'b1) begin
      failures++;
      $display("FAIL toggle_after_pulse got led2=%b want 1", LED_Out[2]);
    end
  endtask

  task automatic test_sync_and_reset();
    logic [NCH-1:0] exp_t;
    do_reset();
    write_step(2'd1, 16'd3, 1'b0);
    write_step(2'd2, 16'd5, 1'b0);
    en = '1;
    repeat (6) step();
    write_step(2'd0, 16'd6, 1'b0);
    checks++;
    if (busy !== 3'b001) begin
      failures++;
      $display("FAIL sync_pre_busy got %b want 001", busy);
    end
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    checks++;
    if (tick !== '0 || LED_Out !== '0 || busy !== '0) begin
      failures++;
      $display("FAIL sync_clear got tick=%b led=%b busy=%b want 000", tick, LED_Out, busy);
    end
    for (int r = 1; r <= 6; r++) begin
      step();
      exp_t = {r == 5, r % 3 == 0, r == 6};
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL sync_align r=%0d got tick=%b want %b", r, tick, exp_t);
      end
    end
    checks++;
    if (LED_Out !== 3'b101) begin
      failures++;
      $display("FAIL sync_led got %b want 101", LED_Out);
    end
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if (tick !== '0 || LED_Out !== '0 || busy !== '0) begin
      failures++;
      $display("FAIL async_reset got tick=%b led=%b busy=%b want 000", tick, LED_Out, busy);
    end
    step();
    RSTn = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      step();
      exp_t = (r == 4) ? '1 : '0;
      checks++;
      if (tick !== exp_t) begin
        failures++;
        $display("FAIL post_reset_div r=%0d got tick=%b want %b", r, tick, exp_t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_pending();
    test_small_div();
    test_bad_ch_and_wrap();
    test_enable();
    test_mode();
    test_sync_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
